// File: rtl/axis_fifo_pkg.sv
// Shared constants and the stored-word layout for the AXI4-Stream FIFO.
// The module-level word type is rebuilt from DATA_WIDTH; this one describes the default.
package axis_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef struct packed {
    logic                          tlast;
    logic                          tuser;
    logic [DEFAULT_DATA_WIDTH-1:0] tdata;
  } axis_word_t;

  // Beats held in total: the RAM plus the single output register.
  function automatic int unsigned fifo_capacity(input int unsigned addr_width);
    return (32'd1 << addr_width) + 32'd1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose
// register doubles as the FIFO output stage.
module axis_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the storage array is deliberately not reset; resetting it would block
  // RAM inference and buys nothing, since the pointers define which words are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_fifo_wrapper.sv
// Single-clock AXI4-Stream FIFO: 2^ADDR_WIDTH-word RAM plus one output register.
// Reset is synchronous, active-high, and also stalls the input handshake.
module axis_fifo_wrapper
  import axis_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  typedef struct packed {
    logic                  tlast;
    logic                  tuser;
    logic [DATA_WIDTH-1:0] tdata;
  } word_t;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic             load;
  word_t            wr_word;
  word_t            rd_word;

  // The extra pointer MSB tells full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign input_axis_tready = !full && !async_rst;
  assign wr_en             = input_axis_tvalid && input_axis_tready;
  assign load              = !empty && (!out_valid || output_axis_tready);

  assign wr_word = '{tlast: input_axis_tlast, tuser: input_axis_tuser, tdata: input_axis_tdata};

  axis_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     ($bits(word_t))
  ) u_ram (
    .clk    (clk),
    .rst    (async_rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(wr_word),
    .rd_en  (load),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(rd_word)
  );

  always_ff @(posedge clk) begin
    if (async_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load)  rd_ptr <= rd_ptr + PTR_W'(1);
      // A load refills the stage even while the current beat is leaving.
      if (load)                    out_valid <= 1'b1;
      else if (output_axis_tready) out_valid <= 1'b0;
    end
  end

  assign output_axis_tvalid = out_valid;
  assign output_axis_tdata  = rd_word.tdata;
  assign output_axis_tlast  = rd_word.tlast;
  assign output_axis_tuser  = rd_word.tuser;

endmodule

// File: tb/tb_axis_fifo_wrapper.sv
// Self-checking bench for axis_fifo_wrapper: a hand-computed vector table, directed
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_axis_fifo_wrapper;
  import axis_fifo_pkg::*;

  localparam int RAM_DEPTH = 1 << DEFAULT_ADDR_WIDTH;

  logic       clk = 1'b0;
  logic       async_rst = 1'b1;
  logic [7:0] in_tdata = '0;
  logic       in_tvalid = 1'b0;
  logic       in_tready;
  logic       in_tlast = 1'b0;
  logic       in_tuser = 1'b0;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready = 1'b0;
  logic       out_tlast;
  logic       out_tuser;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_fifo_wrapper dut (
    .clk               (clk),
    .async_rst         (async_rst),
    .input_axis_tdata  (in_tdata),
    .input_axis_tvalid (in_tvalid),
    .input_axis_tready (in_tready),
    .input_axis_tlast  (in_tlast),
    .input_axis_tuser  (in_tuser),
    .output_axis_tdata (out_tdata),
    .output_axis_tvalid(out_tvalid),
    .output_axis_tready(out_tready),
    .output_axis_tlast (out_tlast),
    .output_axis_tuser (out_tuser)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every beat the FIFO holds, oldest first; the head sits in
  // the output stage when stage_full is set.
  axis_word_t q[$];
  bit         stage_full = 1'b0;
  bit         after_rst  = 1'b0;

  // Drive one cycle's inputs (called at a falling edge), compare, advance model.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit last,
                      input bit user, input bit ready, output bit acc);
    int ram_cnt;
    bit exp_rdy, pop, load;
    async_rst  = rst;
    in_tvalid  = v;
    in_tdata   = d;
    in_tlast   = last;
    in_tuser   = user;
    out_tready = ready;
    #1;
    ram_cnt = q.size() - int'(stage_full);
    exp_rdy = !rst && (ram_cnt < RAM_DEPTH);
    check("tready", in_tready, exp_rdy);
    check("tvalid", out_tvalid, stage_full);
    if (stage_full) begin
      check("tdata", out_tdata, q[0].tdata);
      check("tlast", out_tlast, q[0].tlast);
      check("tuser", out_tuser, q[0].tuser);
    end else if (after_rst) begin
      check("rst_tdata", {out_tlast, out_tuser, out_tdata}, 10'h0);
    end
    acc = v && exp_rdy;
    if (rst) begin
      q.delete();
      stage_full = 1'b0;
      after_rst  = 1'b1;
    end else begin
      pop  = stage_full && ready;
      load = (ram_cnt > 0) && (!stage_full || ready);
      if (pop) void'(q.pop_front());
      stage_full = load || (stage_full && !pop);
      if (load) after_rst = 1'b0;
      if (acc) q.push_back('{tlast: last, tuser: user, tdata: d});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst, v;
    logic [7:0] d;
    bit         last, user, ready;
    bit         exp_rdy, exp_vld, chk_data;
    logic [7:0] exp_d;
    bit         exp_last, exp_user;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit acc;
    int n;
    int cnt;

    vecs[0] = '{1, 1, 8'h01, 0, 0, 1,  0, 0, 1, 8'h00, 0, 0};
    vecs[1] = '{0, 1, 8'h01, 0, 0, 1,  1, 0, 1, 8'h00, 0, 0};
    vecs[2] = '{0, 1, 8'h02, 1, 0, 1,  1, 0, 1, 8'h00, 0, 0};
    vecs[3] = '{0, 1, 8'h03, 0, 1, 0,  1, 1, 1, 8'h01, 0, 0};
    vecs[4] = '{0, 0, 8'h00, 0, 0, 0,  1, 1, 1, 8'h01, 0, 0};
    vecs[5] = '{0, 0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h01, 0, 0};
    vecs[6] = '{0, 0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h02, 1, 0};
    vecs[7] = '{0, 0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h03, 0, 1};
    vecs[8] = '{0, 0, 8'h00, 0, 0, 1,  1, 0, 0, 8'h00, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Table: reset stall, first beat through, stall stability, drain.
    for (int i = 0; i < 9; i++) begin
      async_rst  = vecs[i].rst;
      in_tvalid  = vecs[i].v;
      in_tdata   = vecs[i].d;
      in_tlast   = vecs[i].last;
      in_tuser   = vecs[i].user;
      out_tready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_tready", i), in_tready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_tvalid", i), out_tvalid, vecs[i].exp_vld);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_word", i), {out_tlast, out_tuser, out_tdata},
              {vecs[i].exp_last, vecs[i].exp_user, vecs[i].exp_d});
      @(posedge clk);
      @(negedge clk);
    end

    // Reset held with a beat presented: it must survive to be the first output.
    step(1, 1, 8'h01, 0, 0, 1, acc);
    check("rst_no_accept", acc, 1'b0);
    n = 1;
    cnt = 0;
    // Continuous stream at full rate, tlast on every beat, tuser on beat 3 only.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 8'(n), 1, n == 3, 1, acc);
      if (acc) begin
        n++;
        cnt++;
      end
    end
    check("stream_rate", cnt, 32);
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, acc);

    // Fill while stalled: exactly RAM + output stage beats are taken.
    step(1, 0, 8'h00, 0, 0, 0, acc);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 8'(cnt + 1), 0, 0, 0, acc);
      if (acc) cnt++;
    end
    check("fill_count", cnt, fifo_capacity(DEFAULT_ADDR_WIDTH));
    repeat (20) step(0, 0, 8'h00, 0, 0, 1, acc);
    check("drained_empty", q.size(), 0);

    // Backpressure toggling every cycle.
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 8'(n), n[0], 0, i[0], acc);
      if (acc) n++;
    end
    repeat (40) step(0, 0, 8'h00, 0, 0, 1, acc);

    // Reset with five beats buffered discards them all.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h20 + i), 0, 0, 0, acc);
    step(1, 1, 8'hAA, 1, 1, 0, acc);
    check("midrst_tvalid", out_tvalid, 1'b0);
    check("midrst_tdata", out_tdata, 8'h00);
    n = 8'h50;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'(n), 0, 0, 1, acc);
      if (acc) n++;
    end
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, acc);

    // Randomized traffic including occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, acc);
    end
    repeat (25) step(0, 0, 8'h00, 0, 0, 1, acc);
    check("final_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fifo_wrapper.md
Name: axis_fifo_wrapper

Overview:
Single-clock AXI4-Stream FIFO with 8-bit data plus tlast/tuser sideband, built as a synchronous buffer between an upstream producer and a downstream consumer. It decouples the two handshakes and preserves beat order. Its reset stalls the input side: no beat is accepted while reset is asserted, so data presented during reset is held upstream, not lost.

Parameters:
ADDR_WIDTH, 4, log2 of RAM depth (RAM holds 2^ADDR_WIDTH beats).
DATA_WIDTH, 8, tdata width. Ports below use the default.

Ports:
clk  input  1  clock; all logic on rising edge
async_rst  input  1  reset; synchronous, active-high (port name kept for codebase compatibility)
input_axis_tdata  input  8  input beat data
input_axis_tvalid  input  1  input beat valid
input_axis_tready  output  1  FIFO can accept a beat
input_axis_tlast  input  1  input end-of-frame
input_axis_tuser  input  1  input user/error flag
output_axis_tdata  output  8  output beat data
output_axis_tvalid  output  1  output beat valid
output_axis_tready  input  1  downstream accepts the beat
output_axis_tlast  output  1  output end-of-frame
output_axis_tuser  output  1  output user flag

Behaviour:
- Storage: RAM of 2^ADDR_WIDTH words, each word {tlast, tuser, tdata}, plus one output register stage.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide and binary.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
- input_axis_tready = !full && !async_rst. This is combinational on reset, so tready is 0 in every cycle reset is high.
- Write: when input tvalid && input tready, store the word at wr_ptr[ADDR_WIDTH-1:0] and increment wr_ptr.
- Output stage load: when the RAM is not empty and (output_axis_tvalid == 0 or output_axis_tready == 1):
  - load the word at rd_ptr into the output registers,
  - set output_axis_tvalid to 1,
  - increment rd_ptr.
- Output stage drain: when output tvalid && output tready and no new load occurs, clear output_axis_tvalid.
- Latency: a beat written at edge N appears on the output with tvalid=1 after edge N+1, provided the output stage was free. Throughput is one beat per cycle when tready is held high.
- Ordering: strict FIFO order. A beat accepted first is presented first, including the first beat after reset.
- Output stability: while output_axis_tvalid=1 and output_axis_tready=0, tdata, tlast and tuser are held stable.
- Capacity: 2^ADDR_WIDTH beats in RAM plus 1 in the output stage. When full, tready=0 and the input beat is not consumed.
- Simultaneous events:
  - A write and a read in the same cycle are both performed.
  - A write into an empty RAM is not readable in the same cycle; it is loaded on the next edge.
- Wrap-around: pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
- Reset (async_rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0;
  - output_axis_tvalid=0, output_axis_tdata=0, output_axis_tlast=0, output_axis_tuser=0.
  - No write occurs in that cycle. Reset mid-operation discards all stored beats.
  - RAM contents need not be cleared.
- tuser and tlast are passed through unmodified. No frame dropping.

Decomposition:
- Shared package: default ADDR_WIDTH/DATA_WIDTH constants; a packed typedef for the stored word {tlast, tuser, tdata}.
- One natural sub-module: axis_fifo_ram, a simple dual-port RAM with one write port and a synchronous read into the output register.
- Pointer, flag and output-stage logic stay in axis_fifo_wrapper.

Test Plan:
1. Reset held for 1 cycle with tvalid=1, tdata=0x01 → input_axis_tready=0 during reset. After release the first beat accepted is 0x01, and the first output beat with tvalid&&tready has tdata=0x01.
2. Continuous stream 0x01,0x02,... with tlast=1 and output_axis_tready=1 → outputs appear in order one cycle after acceptance at one beat per cycle; tlast=1 on each.
3. output_axis_tready=0 while writing 17 beats with ADDR_WIDTH=4 → exactly 17 accepted, then tready=0. Releasing tready drains 0x01..0x11 in order.
4. Backpressure toggling every cycle → output_axis_tdata is stable while stalled; no beat is duplicated or lost.
5. Reset asserted mid-stream with the FIFO holding 5 beats → output_axis_tvalid=0 and tdata=0 after the edge; tready=1 after release; the next output is the first beat written after reset.
6. tuser=1 on beat 3 only → output tuser=1 only on beat 3.
